// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: ALU ops, opcode/funct values,
// controller states and instruction classes.
package cpu_ctrl_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_ITYPE, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE
  } instr_class_t;

  function automatic logic is_branch(input instr_class_t c);
    return (c == CLS_BEQ) || (c == CLS_BNE);
  endfunction

  function automatic logic is_mem(input instr_class_t c);
    return (c == CLS_LW) || (c == CLS_SW);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: opcode/funct -> class, ALU op, immediate select
// and an illegal flag for anything outside the supported subset.
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls,
  output logic [2:0]   alu_op,
  output logic         src_imm,
  output logic         illegal
);

  // register and immediate fields are consumed by the datapath, not here
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    cls     = CLS_ITYPE;
    alu_op  = ALU_ADD;
    src_imm = 1'b0;
    illegal = 1'b0;
    case (instr[31:26])
      OP_RTYPE: begin
        cls = CLS_RTYPE;
        case (instr[5:0])
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI: begin
        alu_op  = ALU_OR;
        src_imm = 1'b1;
      end
      OP_LUI: begin
        alu_op  = ALU_LUI;
        src_imm = 1'b1;
      end
      OP_LW: begin
        cls     = CLS_LW;
        src_imm = 1'b1;
      end
      OP_SW: begin
        cls     = CLS_SW;
        src_imm = 1'b1;
      end
      OP_BEQ: begin
        cls    = CLS_BEQ;
        alu_op = ALU_SUB;
      end
      OP_BNE: begin
        cls    = CLS_BNE;
        alu_op = ALU_SUB;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle controller: FETCH->DECODE->EXEC->MEM->WB sequencing with registered
// control strobes, sticky illegal/timeout errors and a bounded memory wait.
//
// state  | meaning
// FETCH  | instr_ready high; capture instruction on instr_valid
// DECODE | instruction classified; illegal ones retire here with pc_write
// EXEC   | ALU op driven; branches resolve on alu_eq and retire
// MEM    | mem_req held until mem_ready or MEM_TIMEOUT cycles elapse
// WB     | reg_we with pc_write, then back to FETCH
module alu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  input  logic        alu_gt,
  input  logic        alu_eq,
  input  logic        alu_lt,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        reg_we,
  output logic        reg_dst_rd,
  output logic        wb_from_mem,
  output logic        pc_write,
  output logic        pc_branch,
  output logic        err_illegal,
  output logic        err_timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t       state, state_d;
  instr_class_t dec_cls, cls_q;
  logic [2:0]   dec_alu_op, op_q;
  logic         dec_src_imm, dec_illegal, imm_q, ill_q;
  logic [CW-1:0] cnt, cnt_d;

  logic [2:0] alu_op_d;
  logic src_imm_d, mem_req_d, mem_we_d, reg_we_d, reg_dst_d, wb_mem_d, pc_write_d;
  logic err_ill_d, err_to_d;

  logic unused_flags;
  assign unused_flags = alu_gt ^ alu_lt;

  instr_decode u_decode (
    .instr   (instr),
    .cls     (dec_cls),
    .alu_op  (dec_alu_op),
    .src_imm (dec_src_imm),
    .illegal (dec_illegal)
  );

  assign instr_ready = (state == FETCH);
  // the branch decision depends on the ALU result of this very cycle
  assign pc_branch   = (state == EXEC) &&
                       (((cls_q == CLS_BEQ) && alu_eq) || ((cls_q == CLS_BNE) && !alu_eq));

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    alu_op_d   = ALU_ADD;
    src_imm_d  = 1'b0;
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    reg_we_d   = 1'b0;
    reg_dst_d  = 1'b0;
    wb_mem_d   = 1'b0;
    pc_write_d = 1'b0;
    err_ill_d  = err_illegal;
    err_to_d   = err_timeout;
    case (state)
      FETCH: begin
        if (instr_valid) begin
          state_d = DECODE;
          if (dec_illegal) begin
            err_ill_d  = 1'b1;
            pc_write_d = 1'b1;
          end
        end
      end
      DECODE: begin
        if (ill_q) begin
          state_d = FETCH;
        end else begin
          state_d    = EXEC;
          alu_op_d   = op_q;
          src_imm_d  = imm_q;
          pc_write_d = is_branch(cls_q);
        end
      end
      EXEC: begin
        if (is_branch(cls_q)) begin
          state_d = FETCH;
        end else if (is_mem(cls_q)) begin
          state_d   = MEM;
          mem_req_d = 1'b1;
          mem_we_d  = (cls_q == CLS_SW);
          cnt_d     = '0;
        end else begin
          state_d    = WB;
          reg_we_d   = 1'b1;
          pc_write_d = 1'b1;
          reg_dst_d  = (cls_q == CLS_RTYPE);
        end
      end
      MEM: begin
        if (mem_ready) begin
          pc_write_d = 1'b1;
          if (cls_q == CLS_LW) begin
            state_d  = WB;
            reg_we_d = 1'b1;
            wb_mem_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
          state_d    = FETCH;
          err_to_d   = 1'b1;
          pc_write_d = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = (cls_q == CLS_SW);
          cnt_d     = cnt + CW'(1);
        end
      end
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      cnt         <= '0;
      cls_q       <= CLS_RTYPE;
      op_q        <= ALU_ADD;
      imm_q       <= 1'b0;
      ill_q       <= 1'b0;
      alu_op      <= ALU_ADD;
      alu_src_imm <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      reg_we      <= 1'b0;
      reg_dst_rd  <= 1'b0;
      wb_from_mem <= 1'b0;
      pc_write    <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      alu_op      <= alu_op_d;
      alu_src_imm <= src_imm_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      reg_we      <= reg_we_d;
      reg_dst_rd  <= reg_dst_d;
      wb_from_mem <= wb_mem_d;
      pc_write    <= pc_write_d;
      err_illegal <= err_ill_d;
      err_timeout <= err_to_d;
      if (state == FETCH && instr_valid) begin
        cls_q <= dec_cls;
        op_q  <= dec_alu_op;
        imm_q <= dec_src_imm;
        ill_q <= dec_illegal;
      end
    end
  end

endmodule
